// File: rtl/prga_check.sv
// rtl/prga_check.sv - ARC4 PRGA keystream generation, decryption and printable-ASCII check
//
// Runs the ARC4 PRGA over a length-prefixed ciphertext once S memory holds a
// freshly scheduled key. Each message byte is decrypted into plaintext memory
// and checked against 0x20..0x7E; the AND of those checks is the per-key verdict.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en / rdy             start request (taken only while rdy=1) / idle indicator
//   valid                verdict of the last completed run (1 = all bytes printable)
//   s_addr/s_rddata/s_wrdata/s_wren      S memory (sync read, one-cycle latency)
//   ct_addr/ct_rddata                    ciphertext memory (ct[0] = length L)
//   pt_addr/pt_wrdata/pt_wren            plaintext memory (pt[0] = L)

module prga_check #(
    parameter int EARLY_ABORT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic       valid,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] RD_LEN    = 4'd1;
    localparam logic [3:0] WAIT_LEN  = 4'd2;
    localparam logic [3:0] LATCH_LEN = 4'd3;
    localparam logic [3:0] RD_I      = 4'd4;
    localparam logic [3:0] WAIT_I    = 4'd5;
    localparam logic [3:0] LATCH_I   = 4'd6;
    localparam logic [3:0] RD_J      = 4'd7;
    localparam logic [3:0] WAIT_J    = 4'd8;
    localparam logic [3:0] LATCH_J   = 4'd9;
    localparam logic [3:0] WR_I      = 4'd10;
    localparam logic [3:0] WR_J      = 4'd11;
    localparam logic [3:0] RD_P      = 4'd12;
    localparam logic [3:0] WAIT_P    = 4'd13;
    localparam logic [3:0] OUT       = 4'd14;

    logic [3:0] state;
    logic [7:0] i;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] len;
    logic [7:0] si;
    logic [7:0] sj;
    logic [7:0] ctb;
    logic       all_ok;
    logic       printable;

    assign rdy = (state == IDLE);

    // In OUT, pt_wrdata holds the byte being written this cycle.
    assign printable = (pt_wrdata >= 8'h20) && (pt_wrdata <= 8'h7E);

    // Memory outputs are registered so each one is valid in the cycle of the
    // state it belongs to; they are loaded on the edge entering that state.
    // Addresses are held between reads so read data stays stable through the
    // WAIT and LATCH cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= 1'b0;
            s_addr    <= 8'd0;
            s_wrdata  <= 8'd0;
            s_wren    <= 1'b0;
            ct_addr   <= 8'd0;
            pt_addr   <= 8'd0;
            pt_wrdata <= 8'd0;
            pt_wren   <= 1'b0;
            i         <= 8'd0;
            j         <= 8'd0;
            k         <= 8'd0;
            len       <= 8'd0;
            si        <= 8'd0;
            sj        <= 8'd0;
            ctb       <= 8'd0;
            all_ok    <= 1'b0;
        end else begin
            s_wren  <= 1'b0;
            pt_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state   <= RD_LEN;
                        valid   <= 1'b0;
                        i       <= 8'd0;
                        j       <= 8'd0;
                        k       <= 8'd1;
                        all_ok  <= 1'b1;
                        ct_addr <= 8'd0;
                    end
                end
                RD_LEN:   state <= WAIT_LEN;
                WAIT_LEN: begin
                    // Length byte is copied through unchecked.
                    state     <= LATCH_LEN;
                    len       <= ct_rddata;
                    pt_addr   <= 8'd0;
                    pt_wrdata <= ct_rddata;
                    pt_wren   <= 1'b1;
                end
                LATCH_LEN: begin
                    if (len == 8'd0) begin
                        state <= IDLE;
                        valid <= 1'b1;
                    end else begin
                        state   <= RD_I;
                        i       <= i + 8'd1;
                        s_addr  <= i + 8'd1;
                        ct_addr <= k;
                    end
                end
                RD_I:   state <= WAIT_I;
                WAIT_I: state <= LATCH_I;
                LATCH_I: begin
                    state  <= RD_J;
                    si     <= s_rddata;
                    ctb    <= ct_rddata;
                    j      <= j + s_rddata;
                    s_addr <= j + s_rddata;
                end
                RD_J:   state <= WAIT_J;
                WAIT_J: state <= LATCH_J;
                LATCH_J: begin
                    state    <= WR_I;
                    sj       <= s_rddata;
                    s_addr   <= i;
                    s_wrdata <= s_rddata;
                    s_wren   <= 1'b1;
                end
                WR_I: begin
                    // When i == j this second write lands on the same
                    // address and leaves si there, as a swap should.
                    state    <= WR_J;
                    s_addr   <= j;
                    s_wrdata <= si;
                    s_wren   <= 1'b1;
                end
                WR_J: begin
                    state  <= RD_P;
                    s_addr <= si + sj;
                end
                RD_P:   state <= WAIT_P;
                WAIT_P: begin
                    state     <= OUT;
                    pt_addr   <= k;
                    pt_wrdata <= s_rddata ^ ctb;
                    pt_wren   <= 1'b1;
                end
                OUT: begin
                    if (!printable && (EARLY_ABORT != 0)) begin
                        state <= IDLE;
                        valid <= 1'b0;
                    end else if (k == len) begin
                        // Compare before incrementing so L=255 never wraps k.
                        state <= IDLE;
                        valid <= all_ok & printable;
                    end else begin
                        state   <= RD_I;
                        all_ok  <= all_ok & printable;
                        k       <= k + 8'd1;
                        ct_addr <= k + 8'd1;
                        i       <= i + 8'd1;
                        s_addr  <= i + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
